// File: rtl/seqdet_pkg.sv
// Shared types, limits and width helpers for the parametrised sequence detector.
package seqdet_pkg;

  typedef enum logic {FILL, RUN} state_t;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

  // The fill count saturates at PAT_W, so it needs to hold 0..PAT_W inclusive.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial data, pattern control and result bus of the sequence detector.
// pat_mask_in exists only when SEQDET_MASK_EN is defined.
interface seq_detector_param_if #(
  parameter int PAT_W = 6,
  parameter int CNT_W = 8
);

  logic             w;
  logic             w_valid;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0] pat_mask_in;
`endif
  logic             cnt_clr;
  logic             z;
  logic             filled;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output w, w_valid, overlap, pat_load, pat_in, cnt_clr,
`ifdef SEQDET_MASK_EN
    output pat_mask_in,
`endif
    input  z, filled, match_cnt
  );

  modport slave (
    input  w, w_valid, overlap, pat_load, pat_in, cnt_clr,
`ifdef SEQDET_MASK_EN
    input  pat_mask_in,
`endif
    output z, filled, match_cnt
  );

endinterface

// File: rtl/seqdet_match_counter.sv
// Saturating match counter; a clear wins over an increment but still counts a
// coincident match, so clear plus match leaves the counter at one.
module seqdet_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable PAT_W-bit serial pattern detector with overlap control
// and a saturating match counter. Define SEQDET_MASK_EN for per-bit don't-care masks.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int               PAT_W     = 6,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(6'b110101)
) (
  input logic                clk,
  input logic                reset,
  seq_detector_param_if.slave bus
);

  localparam int               FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX ||
      CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_params
    $error("seq_detector_param: PAT_W or CNT_W outside the legal range");
  end

  state_t            state;
  state_t            state_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_next;
  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  win;
  logic              consume;
  logic              complete;
  logic              hit;
  logic              match;
  logic              z_q;
  logic              z_next;
  logic              filled_q;
  logic              filled_next;

  // A bit presented together with pat_load is dropped rather than consumed.
  assign consume  = bus.w_valid && !bus.pat_load;
  assign win      = (hist << 1) | PAT_W'(bus.w);
  assign complete = (state == RUN) || (fill == FILL_LAST);

`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0] mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= RESET_PAT;
      mask    <= '1;
    end else if (bus.pat_load) begin
      pattern <= bus.pat_in;
      mask    <= bus.pat_mask_in;
    end
  end

  assign hit = ((win ^ pattern) & mask) == '0;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= RESET_PAT;
    end else if (bus.pat_load) begin
      pattern <= bus.pat_in;
    end
  end

  assign hit = (win == pattern);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      fill     <= '0;
      hist     <= '0;
      z_q      <= 1'b0;
      filled_q <= 1'b0;
    end else begin
      state    <= state_next;
      fill     <= fill_next;
      hist     <= hist_next;
      z_q      <= z_next;
      filled_q <= filled_next;
    end
  end

  // A non-overlapping match restarts the fill; the history keeps shifting but
  // is not compared again until PAT_W fresh bits have arrived.
  always_comb begin
    state_next = state;
    fill_next  = fill;
    hist_next  = hist;
    if (bus.pat_load) begin
      state_next = FILL;
      fill_next  = '0;
      hist_next  = '0;
    end else if (consume) begin
      hist_next = win;
      if (match && !bus.overlap) begin
        state_next = FILL;
        fill_next  = '0;
      end else if (state == FILL) begin
        fill_next = fill + FILL_W'(1);
        if (fill == FILL_LAST) begin
          state_next = RUN;
        end
      end
    end
  end

  always_comb begin
    match       = consume && complete && hit;
    z_next      = match;
    filled_next = (state_next == RUN);
  end

  assign bus.z      = z_q;
  assign bus.filled = filled_q;

  seqdet_match_counter #(
    .CNT_W(CNT_W)
  ) u_match_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (bus.cnt_clr),
    .inc  (match),
    .cnt  (bus.match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed vector table, hand-written
// multi-cycle corner cases, then random traffic against a queue-based reference model.
module tb_seq_detector_param;

  localparam int         PAT_W     = 4;
  localparam int         CNT_W     = 2;
  localparam logic [3:0] RESET_PAT = 4'b1101;
  localparam int         CNT_MAX   = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_if ();

  seq_detector_param #(
    .PAT_W    (PAT_W),
    .CNT_W    (CNT_W),
    .RESET_PAT(RESET_PAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the bits consumed since the last restart (last PAT_W kept).
  logic [3:0] m_pat    = RESET_PAT;
  bit         m_q[$];
  int         m_nbits  = 0;
  int         m_cnt    = 0;
  bit         m_z      = 1'b0;
  bit         m_filled = 1'b0;

  typedef struct {
    logic       rst, w, wv, ov, pl;
    logic [3:0] pi;
    logic       cc;
    logic       z_e, f_e;
    logic [1:0] c_e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vec(input logic rst, w, wv, ov, pl, input logic [3:0] pi,
                               input logic cc, ze, fe, input logic [1:0] ce);
    vec_t v;
    v.rst = rst; v.w = w; v.wv = wv; v.ov = ov; v.pl = pl;
    v.pi = pi; v.cc = cc; v.z_e = ze; v.f_e = fe; v.c_e = ce;
    return v;
  endfunction

  task automatic model_step(input logic rst, w, wv, ov, pl, input logic [3:0] pi,
                            input logic cc);
    bit hit = 1'b0;
    int win = 0;
    if (rst) begin
      m_pat = RESET_PAT; m_q.delete(); m_nbits = 0;
      m_cnt = 0; m_z = 1'b0; m_filled = 1'b0;
    end else begin
      if (pl) begin
        m_pat = pi; m_q.delete(); m_nbits = 0;
      end else if (wv) begin
        m_q.push_back(w);
        if (m_q.size() > PAT_W) void'(m_q.pop_front());
        m_nbits++;
        foreach (m_q[i]) win = (win << 1) | int'(m_q[i]);
        hit = (m_nbits >= PAT_W) && (win == int'(m_pat));
        if (hit && !ov) begin
          m_q.delete(); m_nbits = 0;
        end
      end
      if (cc) m_cnt = hit ? 1 : 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt++;
      m_z = hit;
      m_filled = (m_nbits >= PAT_W);
    end
  endtask

  task automatic applyStimulus(input logic rst, w, wv, ov, pl, input logic [3:0] pi,
                               input logic cc);
    reset           = rst;
    bus_if.w        = w;
    bus_if.w_valid  = wv;
    bus_if.overlap  = ov;
    bus_if.pat_load = pl;
    bus_if.pat_in   = pi;
    bus_if.cnt_clr  = cc;
    model_step(rst, w, wv, ov, pl, pi, cc);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ze, fe, input logic [1:0] ce);
    n_checks++;
    if (bus_if.z !== ze) begin
      n_errors++;
      $display("[TB] FAIL %s z: got %0b expected %0b", name, bus_if.z, ze);
    end
    n_checks++;
    if (bus_if.filled !== fe) begin
      n_errors++;
      $display("[TB] FAIL %s filled: got %0b expected %0b", name, bus_if.filled, fe);
    end
    n_checks++;
    if (bus_if.match_cnt !== ce) begin
      n_errors++;
      $display("[TB] FAIL %s match_cnt: got %0d expected %0d", name, bus_if.match_cnt, ce);
    end
  endtask

  task automatic step(input string name, input logic rst, w, wv, ov, pl,
                      input logic [3:0] pi, input logic cc, ze, fe, input logic [1:0] ce);
    applyStimulus(rst, w, wv, ov, pl, pi, cc);
    checkOutput(name, ze, fe, ce);
  endtask

  initial begin
    int         c;
    logic       ov_r;
    logic [3:0] bits6;
`ifdef SEQDET_MASK_EN
    bus_if.pat_mask_in = '1;
`endif
    reset = 1'b1;
    bus_if.w = 0; bus_if.w_valid = 0; bus_if.overlap = 0;
    bus_if.pat_load = 0; bus_if.pat_in = 0; bus_if.cnt_clr = 0;

    // Overlapping detection of 1011 in 1011011
    tbl.push_back(vec(1, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0, 0, 1, 1, 4'b1011, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 1, 0, 4'b0000, 0, 1, 1, 1));
    tbl.push_back(vec(0, 0, 1, 1, 0, 4'b0000, 0, 0, 1, 1));
    tbl.push_back(vec(0, 1, 1, 1, 0, 4'b0000, 0, 0, 1, 1));
    tbl.push_back(vec(0, 1, 1, 1, 0, 4'b0000, 0, 1, 1, 2));
    tbl.push_back(vec(0, 1, 0, 1, 0, 4'b0000, 0, 0, 1, 2));
    // Same stream non-overlapping: one match, filled drops afterwards
    tbl.push_back(vec(0, 0, 0, 0, 1, 4'b1011, 1, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 0, 0, 4'b0000, 0, 1, 0, 1));
    tbl.push_back(vec(0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(vec(0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(vec(0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
    // Gapped stream: w_valid low for three cycles between bits
    tbl.push_back(vec(0, 0, 0, 1, 1, 4'b1011, 1, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(vec(0, 1, 0, 1, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(vec(0, 1, 0, 1, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(vec(0, 1, 0, 1, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(vec(0, 1, 1, 1, 0, 4'b0000, 0, 1, 1, 1));
    tbl.push_back(vec(0, 0, 0, 1, 0, 4'b0000, 0, 0, 1, 1));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].w, tbl[i].wv, tbl[i].ov, tbl[i].pl,
                    tbl[i].pi, tbl[i].cc);
      checkOutput($sformatf("vec%0d", i), tbl[i].z_e, tbl[i].f_e, tbl[i].c_e);
    end

    // Counter saturation: four more overlapping matches of 1011 (five in total)
    c = 1;
    for (int k = 0; k < 4; k++) begin
      step("sat_b0", 0, 0, 1, 1, 0, 4'b0000, 0, 0, 1, 2'(c));
      step("sat_b1", 0, 1, 1, 1, 0, 4'b0000, 0, 0, 1, 2'(c));
      c = (c < CNT_MAX) ? c + 1 : CNT_MAX;
      step("sat_hit", 0, 1, 1, 1, 0, 4'b0000, 0, 1, 1, 2'(c));
    end
    step("clr_b0", 0, 0, 1, 1, 0, 4'b0000, 0, 0, 1, 3);
    step("clr_b1", 0, 1, 1, 1, 0, 4'b0000, 0, 0, 1, 3);
    step("clr_with_match", 0, 1, 1, 1, 0, 4'b0000, 1, 1, 1, 1);
    step("clr_alone", 0, 0, 0, 1, 0, 4'b0000, 1, 0, 1, 0);

    // pat_load with a valid bit: the bit is dropped, 0110 found after 1,1,0,1,1,0
    step("load_drop", 0, 0, 1, 1, 1, 4'b0110, 0, 0, 0, 0);
    bits6 = 4'b0000;
    step("load_b1", 0, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    step("load_b2", 0, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    step("load_b3", 0, 0, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    step("load_b4", 0, 1, 1, 1, 0, 4'b0000, 0, 0, 1, 0);
    step("load_b5", 0, 1, 1, 1, 0, 4'b0000, 0, 0, 1, 0);
    step("load_hit", 0, 0, 1, 1, 0, bits6, 0, 1, 1, 1);

    // Reset on the cycle that would complete a match; pattern reverts to RESET_PAT
    step("rst_b1", 0, 1, 1, 1, 0, 4'b0000, 0, 0, 1, 1);
    step("rst_b2", 0, 1, 1, 1, 0, 4'b0000, 0, 0, 1, 1);
    step("rst_mid_match", 1, 0, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    step("rp_b1", 0, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    step("rp_b2", 0, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    step("rp_b3", 0, 0, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    step("rp_hit", 0, 1, 1, 1, 0, 4'b0000, 0, 1, 1, 1);

    // Random traffic against the reference model
    applyStimulus(1, 0, 0, 0, 0, 4'b0000, 0);
    checkOutput("rand_reset", m_z, m_filled, 2'(m_cnt));
    ov_r = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) ov_r = ~ov_r;
      applyStimulus(($urandom_range(0, 199) == 0),
                    1'($urandom()),
                    ($urandom_range(0, 3) != 0),
                    ov_r,
                    ($urandom_range(0, 39) == 0),
                    4'($urandom()),
                    ($urandom_range(0, 24) == 0));
      checkOutput("rand", m_z, m_filled, 2'(m_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
